rf_wb_arbiter: RTL and testbench

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter_pkg.sv | 12 +
 rtl/rf_wb_arbiter_rr_arb2.sv | 34 +++
 rtl/rf_wb_arbiter.sv | 76 +++++++
 tb/tb_rf_wb_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// rtl/rf_wb_arbiter_pkg.sv - shared widths and requester-select encoding for the writeback arbiter
package rf_wb_arbiter_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } sel_e;

endpackage

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// rtl/rf_wb_arbiter_rr_arb2.sv - two-requester grant logic with same-address ordering and round-robin tie break
module rr_arb2
    import rf_wb_arbiter_pkg::*;
(
    input  logic a_valid,
    input  logic b_valid,
    input  logic same_addr,
    input  sel_e rr,
    input  logic stall,
    output logic a_grant,
    output logic b_grant
);

    always_comb begin
        a_grant = 1'b0;
        b_grant = 1'b0;
        if (!stall) begin
            if (a_valid && b_valid) begin
                // Load goes first on a shared destination so the ALU result lands last.
                if (same_addr) begin
                    b_grant = 1'b1;
                end else if (rr == SEL_A) begin
                    a_grant = 1'b1;
                end else begin
                    b_grant = 1'b1;
                end
            end else begin
                a_grant = a_valid;
                b_grant = b_valid;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - shares the register-file write port between ALU and load writeback
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    input  logic              stall,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_write_add,
    output logic [DATA_W-1:0] rf_data,
    output logic [7:0]        zero_drops
);

    sel_e              rr;
    logic              same_addr;
    logic              accept;
    logic              rr_decided;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    assign same_addr = (a_addr == b_addr);

    // Reset is folded into the hold input so no request is taken while rst is high.
    rr_arb2 u_arb (
        .a_valid   (a_valid),
        .b_valid   (b_valid),
        .same_addr (same_addr),
        .rr        (rr),
        .stall     (stall | rst),
        .a_grant   (a_ready),
        .b_grant   (b_ready)
    );

    assign accept     = a_ready | b_ready;
    assign rr_decided = a_valid & b_valid & ~same_addr & accept;
    assign win_addr   = a_ready ? a_addr : b_addr;
    assign win_data   = a_ready ? a_data : b_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_write     <= 1'b0;
            rf_write_add <= '0;
            rf_data      <= '0;
            zero_drops   <= 8'd0;
            rr           <= SEL_A;
        end else begin
            rf_write <= 1'b0;
            if (accept) begin
                if (win_addr == '0) begin
                    if (zero_drops != 8'hFF) begin
                        zero_drops <= zero_drops + 8'd1;
                    end
                end else begin
                    rf_write     <= 1'b1;
                    rf_write_add <= win_addr;
                    rf_data      <= win_data;
                end
            end
            if (rr_decided) begin
                rr <= (rr == SEL_A) ? SEL_B : SEL_A;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - scoreboard bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_valid, b_valid, stall;
    logic          a_ready, b_ready;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_data, b_data;
    logic          rf_write;
    logic [AW-1:0] rf_write_add;
    logic [DW-1:0] rf_data;
    logic [7:0]    zero_drops;

    rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_addr       (a_addr),
        .a_data       (a_data),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .b_addr       (b_addr),
        .b_data       (b_data),
        .stall        (stall),
        .rf_write     (rf_write),
        .rf_write_add (rf_write_add),
        .rf_data      (rf_data),
        .zero_drops   (zero_drops)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int edge_cnt    = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int            tag;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t expq[$];
    int  m_rr   = 0;   // 0 = A next on a conflict, 1 = B
    int  m_zero = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Applies one cycle of stimulus, checks readies against the rule-level model
    // and records the write the register file should see one cycle later.
    task automatic drive_cycle(input logic r, input logic av, input logic [AW-1:0] aa,
                               input logic [DW-1:0] ad, input logic bv, input logic [AW-1:0] ba,
                               input logic [DW-1:0] bd, input logic st);
        bit            ga, gb;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        @(negedge clk);
        check("zero_drops", {56'd0, zero_drops}, m_zero);
        rst = r; a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd; stall = st;
        #1;
        ga = 0; gb = 0;
        if (!r && !st) begin
            if (av && bv) begin
                if (aa == ba) begin
                    gb = 1;
                end else begin
                    if (m_rr == 0) ga = 1; else gb = 1;
                    m_rr = 1 - m_rr;
                end
            end else begin
                ga = av;
                gb = bv;
            end
        end
        check("a_ready", a_ready, ga);
        check("b_ready", b_ready, gb);
        if (r) begin
            m_rr   = 0;
            m_zero = 0;
        end else if (ga || gb) begin
            wa = ga ? aa : ba;
            wd = ga ? ad : bd;
            if (wa == 0) begin
                if (m_zero < 255) m_zero++;
            end else begin
                expq.push_back('{edge_cnt + 1, wa, wd});
            end
        end
    endtask

    task automatic idle();
        drive_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_reset_values(input string tag);
        @(negedge clk);
        check({tag, "_rf_write"}, rf_write, 0);
        check({tag, "_rf_write_add"}, rf_write_add, 0);
        check({tag, "_rf_data"}, rf_data, 0);
        check({tag, "_zero_drops"}, zero_drops, 0);
    endtask

    // Monitor: compares every cycle's write port against the scoreboard.
    initial begin
        wr_t e;
        bit  exp_w;
        forever begin
            @(posedge clk);
            #2;
            while (expq.size() > 0 && expq[0].tag < edge_cnt) begin
                e = expq.pop_front();
                check("rf_write_missed", 0, 1);
            end
            exp_w = (expq.size() > 0 && expq[0].tag == edge_cnt);
            check("rf_write", rf_write, exp_w);
            if (exp_w) begin
                e = expq.pop_front();
                check("rf_write_add", rf_write_add, e.addr);
                check("rf_data", rf_data, e.data);
            end
        end
    end

    initial begin
        rst = 1; a_valid = 0; b_valid = 0; stall = 0;
        a_addr = 0; b_addr = 0; a_data = 0; b_data = 0;
        drive_cycle(1, 1, 3, 32'h5, 1, 4, 32'h6, 0);
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 0);
        check_reset_values("reset");

        // Single ALU write
        drive_cycle(0, 1, 5, 32'h1234, 0, 0, 0, 0);
        idle();

        // Conflict, different addresses, held valid; pointer should return to A
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 0);
        drive_cycle(0, 1, 3, 32'hA, 1, 4, 32'hB, 0);
        drive_cycle(0, 1, 3, 32'hA, 1, 4, 32'hB, 0);
        idle();
        drive_cycle(0, 1, 3, 32'hC, 1, 4, 32'hD, 0);
        idle();

        // Conflict, same address: load first, then ALU
        drive_cycle(0, 1, 7, 32'h11, 1, 7, 32'h22, 0);
        drive_cycle(0, 1, 7, 32'h11, 0, 0, 0, 0);
        idle();

        // Stall holds both off for three cycles
        for (int i = 0; i < 3; i++) drive_cycle(0, 1, 8, 32'h80, 1, 9, 32'h90, 1);
        drive_cycle(0, 1, 8, 32'h80, 1, 9, 32'h90, 0);
        drive_cycle(0, 1, 8, 32'h80, 1, 9, 32'h90, 0);
        idle();

        // Writes to x0 are consumed and counted up to saturation
        for (int i = 0; i < 300; i++) drive_cycle(0, 1, 0, $urandom, 0, 0, 0, 0);
        idle();
        @(negedge clk);
        check("zero_drops_sat", zero_drops, 255);

        // Reset right after an acceptance
        drive_cycle(0, 1, 9, 32'hBEEF, 0, 0, 0, 0);
        drive_cycle(1, 1, 10, 32'hCAFE, 1, 11, 32'hF00D, 0);
        check_reset_values("mid_reset");
        idle();

        for (int i = 0; i < 2000; i++) begin
            drive_cycle(($urandom_range(0, 49) == 0),
                        ($urandom_range(0, 9) < 7), AW'($urandom_range(0, 3)), $urandom,
                        ($urandom_range(0, 9) < 7), AW'($urandom_range(0, 3)), $urandom,
                        ($urandom_range(0, 4) == 0));
        end
        idle();
        idle();
        @(negedge clk);
        check("scoreboard_drained", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
